depth_window_stats: RTL and testbench
=====================================

Name: depth_window_stats

Overview:
- Downstream consumer of the per-cycle logic-depth analyzer.
- Takes the analyzer's depth and flip-flop samples over a fixed window of 2**WIN_LOG2 accepted samples.
- For each window it produces max, min, truncated-average depth, total flip-flop count and a count of samples over a depth limit.
- Presents each window summary on a valid/ready output held under backpressure; feeds the timing-risk reporting stage.

Parameters:
- DW, 8, width of depth and flip-flop samples.
- WIN_LOG2, 3, log2 of window length (default window = 8 samples); legal range 1..6.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the partial window and any pending result.
- in_valid  input  1  depth_in/ff_in carry a sample.
- in_ready  output  1  block can accept a sample; combinational from state (1 in ACCUM, 0 in HOLD).
- depth_in  input  DW  logic depth sample.
- ff_in  input  DW  flip-flop count sample.
- depth_limit  input  DW  violation threshold, sampled per accepted sample.
- out_valid  output  1  window summary available.
- out_ready  input  1  consumer accepts summary.
- max_depth  output  DW  largest depth_in in window.
- min_depth  output  DW  smallest depth_in in window.
- avg_depth  output  DW  depth sum >> WIN_LOG2 (truncating).
- ff_total  output  DW+WIN_LOG2  sum of ff_in over window; exact, cannot overflow.
- viol_count  output  WIN_LOG2+1  number of samples with depth_in > depth_limit (strict).
- viol_flag  output  1  viol_count != 0.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (async, immediate, no clock edge needed): state=ACCUM, sample counter=0, depth_sum=0, ff_sum=0, run_max=0, run_min=all-ones, run_viol=0. All outputs 0, out_valid=0. in_ready=1 once state=ACCUM.
- Accept: a sample is accepted when in_valid && in_ready at a rising edge. Idle cycles (in_valid=0) do not advance the window.
- ACCUM per accept:
  - depth_sum += depth_in (width DW+WIN_LOG2); ff_sum += ff_in.
  - run_max = max(run_max, depth_in); run_min = min(run_min, depth_in).
  - run_viol += (depth_in > depth_limit); counter += 1.
- Window completion: on the accept that makes counter == 2**WIN_LOG2, the same edge must:
  - load output registers from the running values including that final sample;
  - set out_valid=1, so out_valid is visible the cycle after the final accept;
  - go to HOLD;
  - clear counter and accumulators to their reset values.
- HOLD:
  - in_ready=0; in_valid ignored.
  - All outputs must remain stable until out_valid && out_ready.
  - On that handshake edge: out_valid=0, state=ACCUM; in_ready=1 from the next cycle. Output data registers keep their last values.
  - A handshake and a new accept never occur in the same cycle.
- out_ready while out_valid=0: no effect.
- clear (priority below rst_n, above everything else): at the edge, counter/accumulators return to reset values, out_valid=0, state=ACCUM. Output data registers are not zeroed; a pending summary is dropped.
- Window-boundary edge cases: clear coinciding with a final accept means the sample is discarded and no summary is produced. Reset mid-window or mid-HOLD discards everything.
- Arithmetic: all unsigned. Comparisons are on full DW bits. avg_depth is always <= max_depth and >= min_depth.

Decomposition:
- Package depth_stats_pkg holds:
  - state enum {ACCUM, HOLD};
  - helper constants: window length = 1 << WIN_LOG2, sum width = DW + WIN_LOG2, count width = WIN_LOG2 + 1.
- Sub-module depth_minmax_tracker: holds run_max/run_min with load-on-accept and restart-on-clear/complete. Top level holds the FSM, counter, sums and output registers.

Test Plan:
- After reset, 8 contiguous samples depth=1..8, ff=2 each, depth_limit=5 -> out_valid rises the cycle after 8th accept; max=8, min=1, avg=4 (36>>3), ff_total=16, viol_count=3, viol_flag=1.
- Repeat first window, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs unchanged throughout. Raise out_ready -> out_valid drops next edge, in_ready=1 the following cycle. Next window depth=3 x8, limit=5 -> max=min=avg=3, viol_count=0, viol_flag=0.
- 8 samples depth=255, ff=255, depth_limit=255 -> avg=255, ff_total=2040, max=min=255, viol_count=0 (strict compare, no overflow).
- Same data as scenario 1 with in_valid low on alternate cycles -> identical summary values; out_valid timing relative to 8th accept unchanged.
- 5 samples depth=200, pulse clear, then 8 samples depth=10 -> summary max=min=avg=10; earlier samples excluded.
- Deassert rst_n between clock edges mid-window and during HOLD -> out_valid and all outputs go 0 immediately, in_ready=1. After release, a fresh 8-sample window is required before out_valid.

Source files
------------

// File: rtl/depth_stats_pkg.sv
// depth_stats_pkg: shared state encoding and width helpers for the
// depth_window_stats block.
`default_nettype none

package depth_stats_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int win_len(input int win_log2);
    return 1 << win_log2;
  endfunction

  function automatic int sum_w(input int dw, input int win_log2);
    return dw + win_log2;
  endfunction

  function automatic int cnt_w(input int win_log2);
    return win_log2 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/depth_minmax_tracker.sv
// depth_minmax_tracker: running max/min of accepted depth samples, with
// next-value outputs that already include the sample being accepted.
`default_nettype none

module depth_minmax_tracker
  import depth_stats_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          accept,
  input  logic [DW-1:0] depth_in,
  output logic [DW-1:0] run_max,
  output logic [DW-1:0] run_min,
  output logic [DW-1:0] max_next,
  output logic [DW-1:0] min_next
);

  logic [DW-1:0] run_max_q, run_max_d;
  logic [DW-1:0] run_min_q, run_min_d;

  assign max_next = (depth_in > run_max_q) ? depth_in : run_max_q;
  assign min_next = (depth_in < run_min_q) ? depth_in : run_min_q;
  assign run_max  = run_max_q;
  assign run_min  = run_min_q;

  // Restart wins over accept so a completing window starts the next one clean.
  always_comb begin
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    if (restart) begin
      run_max_d = '0;
      run_min_d = '1;
    end else if (accept) begin
      run_max_d = max_next;
      run_min_d = min_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max_q <= '0;
      run_min_q <= '1;
    end else begin
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/depth_window_stats.sv
// depth_window_stats: per-window max/min/average depth, flip-flop total and
// over-limit count, presented on a valid/ready output held under backpressure.
`default_nettype none

module depth_window_stats
  import depth_stats_pkg::*;
#(
  parameter int DW       = 8,
  parameter int WIN_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          depth_in,
  input  logic [DW-1:0]          ff_in,
  input  logic [DW-1:0]          depth_limit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          max_depth,
  output logic [DW-1:0]          min_depth,
  output logic [DW-1:0]          avg_depth,
  output logic [DW+WIN_LOG2-1:0] ff_total,
  output logic [WIN_LOG2:0]      viol_count,
  output logic                   viol_flag
);

  localparam int WIN_LEN = win_len(WIN_LOG2);
  localparam int SW      = sum_w(DW, WIN_LOG2);
  localparam int CW      = cnt_w(WIN_LOG2);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIN_LEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   dsum_q, dsum_d;
  logic [SW-1:0]   fsum_q, fsum_d;
  logic [CW-1:0]   viol_q, viol_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   max_q, max_d;
  logic [DW-1:0]   min_q, min_d;
  logic [DW-1:0]   avg_q, avg_d;
  logic [SW-1:0]   fft_q, fft_d;
  logic [CW-1:0]   vc_q, vc_d;

  logic            accept;
  logic            last_accept;
  logic [SW-1:0]   dsum_nx;
  logic [SW-1:0]   fsum_nx;
  logic [CW-1:0]   viol_nx;
  logic [DW-1:0]   run_max, run_min, max_next, min_next;

  assign in_ready    = (state_q == ACCUM);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (cnt_q == LAST_CNT);

  assign dsum_nx = dsum_q + {{WIN_LOG2{1'b0}}, depth_in};
  assign fsum_nx = fsum_q + {{WIN_LOG2{1'b0}}, ff_in};
  assign viol_nx = viol_q + {{WIN_LOG2{1'b0}}, (depth_in > depth_limit)};

  depth_minmax_tracker #(
    .DW (DW)
  ) u_minmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (clear || last_accept),
    .accept   (accept && !clear),
    .depth_in (depth_in),
    .run_max  (run_max),
    .run_min  (run_min),
    .max_next (max_next),
    .min_next (min_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dsum_d      = dsum_q;
    fsum_d      = fsum_q;
    viol_d      = viol_q;
    out_valid_d = out_valid_q;
    max_d       = max_q;
    min_d       = min_q;
    avg_d       = avg_q;
    fft_d       = fft_q;
    vc_d        = vc_q;

    if (clear) begin
      // Output data registers deliberately keep their last values.
      state_d     = ACCUM;
      cnt_d       = '0;
      dsum_d      = '0;
      fsum_d      = '0;
      viol_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (last_accept) begin
            max_d       = max_next;
            min_d       = min_next;
            avg_d       = DW'(dsum_nx >> WIN_LOG2);
            fft_d       = fsum_nx;
            vc_d        = viol_nx;
            out_valid_d = 1'b1;
            state_d     = HOLD;
            cnt_d       = '0;
            dsum_d      = '0;
            fsum_d      = '0;
            viol_d      = '0;
          end else if (accept) begin
            cnt_d  = cnt_q + 1'b1;
            dsum_d = dsum_nx;
            fsum_d = fsum_nx;
            viol_d = viol_nx;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      dsum_q      <= '0;
      fsum_q      <= '0;
      viol_q      <= '0;
      out_valid_q <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      avg_q       <= '0;
      fft_q       <= '0;
      vc_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dsum_q      <= dsum_d;
      fsum_q      <= fsum_d;
      viol_q      <= viol_d;
      out_valid_q <= out_valid_d;
      max_q       <= max_d;
      min_q       <= min_d;
      avg_q       <= avg_d;
      fft_q       <= fft_d;
      vc_q        <= vc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign max_depth  = max_q;
  assign min_depth  = min_q;
  assign avg_depth  = avg_q;
  assign ff_total   = fft_q;
  assign viol_count = vc_q;
  assign viol_flag  = (vc_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_depth_window_stats.sv
// tb_depth_window_stats: directed stimulus checked every cycle against a
// queue-based window model, plus literal checks on key summaries.
`default_nettype none

module tb_depth_window_stats;

  localparam int DW = 8;
  localparam int WL = 3;
  localparam int WN = 1 << WL;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     depth_in = '0;
  logic [DW-1:0]     ff_in = '0;
  logic [DW-1:0]     depth_limit = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     max_depth, min_depth, avg_depth;
  logic [DW+WL-1:0]  ff_total;
  logic [WL:0]       viol_count;
  logic              viol_flag;

  int n_cmp = 0;
  int n_bad = 0;

  depth_window_stats #(.DW(DW), .WIN_LOG2(WL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .depth_in    (depth_in),
    .ff_in       (ff_in),
    .depth_limit (depth_limit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .max_depth   (max_depth),
    .min_depth   (min_depth),
    .avg_depth   (avg_depth),
    .ff_total    (ff_total),
    .viol_count  (viol_count),
    .viol_flag   (viol_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Window model: collect accepted samples, summarise when the window is full.
  int m_dep[$];
  int m_ff[$];
  int m_lim[$];
  bit m_hold = 0;
  int m_max = 0, m_min = 0, m_avg = 0, m_fft = 0, m_vc = 0;

  task automatic model_reset();
    m_dep.delete(); m_ff.delete(); m_lim.delete();
    m_hold = 0;
    m_max = 0; m_min = 0; m_avg = 0; m_fft = 0; m_vc = 0;
  endtask

  task automatic model_summarise();
    int mx, mn, s, f, v;
    mx = 0; mn = 255; s = 0; f = 0; v = 0;
    for (int i = 0; i < WN; i++) begin
      if (m_dep[i] > mx) mx = m_dep[i];
      if (m_dep[i] < mn) mn = m_dep[i];
      s += m_dep[i];
      f += m_ff[i];
      if (m_dep[i] > m_lim[i]) v++;
    end
    m_max = mx; m_min = mn; m_avg = s / WN; m_fft = f; m_vc = v;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      if (clear) begin
        m_dep.delete(); m_ff.delete(); m_lim.delete();
        m_hold = 0;
      end else if (!m_hold) begin
        if (in_valid) begin
          m_dep.push_back(int'(depth_in));
          m_ff.push_back(int'(ff_in));
          m_lim.push_back(int'(depth_limit));
          if (m_dep.size() == WN) begin
            model_summarise();
            m_hold = 1;
            m_dep.delete(); m_ff.delete(); m_lim.delete();
          end
        end
      end else if (out_ready) begin
        m_hold = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",   int'(in_ready),   int'(!m_hold));
      chk("out_valid",  int'(out_valid),  int'(m_hold));
      chk("max_depth",  int'(max_depth),  m_max);
      chk("min_depth",  int'(min_depth),  m_min);
      chk("avg_depth",  int'(avg_depth),  m_avg);
      chk("ff_total",   int'(ff_total),   m_fft);
      chk("viol_count", int'(viol_count), m_vc);
      chk("viol_flag",  int'(viol_flag),  int'(m_vc != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int f, input int lim);
    in_valid    = 1'b1;
    depth_in    = DW'(d);
    ff_in       = DW'(f);
    depth_limit = DW'(lim);
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid_low", int'(out_valid), 0);
    chk("hs_in_ready_high", int'(in_ready), 1);
  endtask

  task automatic chk_summary(input string tag, input int mx, input int mn,
                             input int av, input int ft, input int vc);
    chk({tag, "_valid"}, int'(out_valid),  1);
    chk({tag, "_max"},   int'(max_depth),  mx);
    chk({tag, "_min"},   int'(min_depth),  mn);
    chk({tag, "_avg"},   int'(avg_depth),  av);
    chk({tag, "_fft"},   int'(ff_total),   ft);
    chk({tag, "_vc"},    int'(viol_count), vc);
    chk({tag, "_flag"},  int'(viol_flag),  int'(vc != 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(out_valid),  0);
    chk({tag, "_ready"}, int'(in_ready),   1);
    chk({tag, "_max"},   int'(max_depth),  0);
    chk({tag, "_min"},   int'(min_depth),  0);
    chk({tag, "_avg"},   int'(avg_depth),  0);
    chk({tag, "_fft"},   int'(ff_total),   0);
    chk({tag, "_vc"},    int'(viol_count), 0);
    chk({tag, "_flag"},  int'(viol_flag),  0);
  endtask

  task automatic async_reset_pulse();
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Ascending window, limit 5.
    for (int i = 1; i <= 8; i++) send(i, 2, 5);
    chk_summary("w1", 8, 1, 4, 16, 3);
    handshake();

    // Same window, then backpressure with in_valid held high.
    for (int i = 1; i <= 8; i++) send(i, 2, 5);
    in_valid = 1'b1; depth_in = 8'd99; ff_in = 8'd99; depth_limit = 8'd0;
    repeat (5) tick();
    chk("bp_in_ready", int'(in_ready), 0);
    chk_summary("bp", 8, 1, 4, 16, 3);
    in_valid = 1'b0;
    handshake();
    for (int i = 0; i < 8; i++) send(3, 1, 5);
    chk_summary("flat3", 3, 3, 3, 8, 0);
    handshake();

    // Saturated values, strict comparison.
    for (int i = 0; i < 8; i++) send(255, 255, 255);
    chk_summary("sat", 255, 255, 255, 2040, 0);
    handshake();

    // Gapped input stream.
    for (int i = 1; i <= 8; i++) begin
      send(i, 2, 5);
      if (i < 8) idle(1);
    end
    chk_summary("gap", 8, 1, 4, 16, 3);
    handshake();

    // Clear mid-window, then clear on the final accept.
    for (int i = 0; i < 5; i++) send(200, 7, 100);
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 7; i++) send(50, 1, 0);
    clear = 1'b1; send(50, 1, 0); clear = 1'b0;
    chk("clear_last_valid", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) send(10, 3, 9);
    chk_summary("clr", 10, 10, 10, 24, 8);
    handshake();

    // Async reset mid-window and during HOLD.
    for (int i = 0; i < 3; i++) send(40, 1, 0);
    async_reset_pulse();
    for (int i = 0; i < 7; i++) send(20, 1, 30);
    chk("fresh_not_yet", int'(out_valid), 0);
    send(20, 1, 30);
    chk_summary("fresh", 20, 20, 20, 8, 0);
    idle(2);
    async_reset_pulse();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
